// File: rtl/serial_comparator_seq.sv
// Bit-serial magnitude comparator sequencer: streams operand bit pairs MSB-first
// through an external 1-bit comparator and folds its verdicts into one result.
module serial_comparator_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             i_w_clk,
   input  logic             i_w_rst_n,
   input  logic             i_w_valid,
   output logic             o_w_ready,
   input  logic [WIDTH-1:0] i_w_a,
   input  logic [WIDTH-1:0] i_w_b,
   output logic             o_w_bit_a,
   output logic             o_w_bit_b,
   input  logic             i_w_bit_lt,
   input  logic             i_w_bit_gt,
   input  logic             i_w_bit_eq,
   output logic             o_w_res_valid,
   input  logic             i_w_res_ready,
   output logic             o_w_lt,
   output logic             o_w_gt,
   output logic             o_w_eq,
   output logic             o_w_err,
   output logic [CNT_W-1:0] o_w_cycles
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_sh_a;
   logic [WIDTH-1:0]   r_sh_b;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   r_cyc;
   logic               r_lt;
   logic               r_gt;
   logic               r_eq;
   logic               r_err;
   logic [CNT_W-1:0]   r_cycles;

   logic               w_onehot;
   logic [CNT_W-1:0]   w_cyc_next;

   assign w_onehot   = $onehot({i_w_bit_lt, i_w_bit_gt, i_w_bit_eq});
   assign w_cyc_next = r_cyc + CNT_W'(1);

   always_ff @(posedge i_w_clk) begin
      if (!i_w_rst_n) begin
         r_state  <= S_IDLE;
         r_sh_a   <= '0;
         r_sh_b   <= '0;
         r_cnt    <= '0;
         r_cyc    <= '0;
         r_lt     <= 1'b0;
         r_gt     <= 1'b0;
         r_eq     <= 1'b0;
         r_err    <= 1'b0;
         r_cycles <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_w_valid) begin
                  r_sh_a  <= i_w_a;
                  r_sh_b  <= i_w_b;
                  r_cnt   <= CNT_W'(WIDTH - 1);
                  r_cyc   <= '0;
                  r_state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               r_cyc <= w_cyc_next;
               // Result registers are only written on the exit to DONE so they
               // stay stable from one handshake to the next.
               if (!w_onehot) begin
                  {r_lt, r_gt, r_eq, r_err} <= 4'b0001;
                  r_cycles <= w_cyc_next;
                  r_state  <= S_DONE;
               end else if (i_w_bit_gt) begin
                  {r_lt, r_gt, r_eq, r_err} <= 4'b0100;
                  r_cycles <= w_cyc_next;
                  r_state  <= S_DONE;
               end else if (i_w_bit_lt) begin
                  {r_lt, r_gt, r_eq, r_err} <= 4'b1000;
                  r_cycles <= w_cyc_next;
                  r_state  <= S_DONE;
               end else if (r_cnt == '0) begin
                  {r_lt, r_gt, r_eq, r_err} <= 4'b0010;
                  r_cycles <= w_cyc_next;
                  r_state  <= S_DONE;
               end else begin
                  r_sh_a <= {r_sh_a[WIDTH-2:0], 1'b0};
                  r_sh_b <= {r_sh_b[WIDTH-2:0], 1'b0};
                  r_cnt  <= r_cnt - CNT_W'(1);
               end
            end
            S_DONE: begin
               if (i_w_res_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_w_ready     = (r_state == S_IDLE);
   assign o_w_res_valid = (r_state == S_DONE);
   assign o_w_bit_a     = (r_state == S_SHIFT) & r_sh_a[WIDTH-1];
   assign o_w_bit_b     = (r_state == S_SHIFT) & r_sh_b[WIDTH-1];
   assign o_w_lt        = r_lt;
   assign o_w_gt        = r_gt;
   assign o_w_eq        = r_eq;
   assign o_w_err       = r_err;
   assign o_w_cycles    = r_cycles;

endmodule

// File: tb/tb_serial_comparator_seq.sv
// Scoreboard bench for serial_comparator_seq: directed operand pairs, ideal or
// faulty 1-bit comparator model, monitor checks results and latency.
module tb_serial_comparator_seq;

   localparam int WIDTH = 8;
   localparam int CNT_W = 4;

   typedef struct packed {
      logic             lt;
      logic             gt;
      logic             eq;
      logic             err;
      logic [CNT_W-1:0] cyc;
      int               lat;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             i_valid;
   logic             o_ready;
   logic [WIDTH-1:0] i_a;
   logic [WIDTH-1:0] i_b;
   logic             bit_a;
   logic             bit_b;
   logic             bit_lt;
   logic             bit_gt;
   logic             bit_eq;
   logic             res_valid;
   logic             res_ready;
   logic             o_lt;
   logic             o_gt;
   logic             o_eq;
   logic             o_err;
   logic [CNT_W-1:0] o_cycles;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   acc_cyc  = 0;
   int   sidx     = 0;
   int   fault_at = 0;
   bit   seen     = 0;
   exp_t q[$];

   serial_comparator_seq #(.WIDTH(WIDTH)) dut (
      .i_w_clk       (clk),
      .i_w_rst_n     (rst_n),
      .i_w_valid     (i_valid),
      .o_w_ready     (o_ready),
      .i_w_a         (i_a),
      .i_w_b         (i_b),
      .o_w_bit_a     (bit_a),
      .o_w_bit_b     (bit_b),
      .i_w_bit_lt    (bit_lt),
      .i_w_bit_gt    (bit_gt),
      .i_w_bit_eq    (bit_eq),
      .o_w_res_valid (res_valid),
      .i_w_res_ready (res_ready),
      .o_w_lt        (o_lt),
      .o_w_gt        (o_gt),
      .o_w_eq        (o_eq),
      .o_w_err       (o_err),
      .o_w_cycles    (o_cycles)
   );

   always #5 clk = ~clk;

   // 1-bit comparator model; fault_at=n forces lt=gt=1 on the n-th SHIFT cycle
   wire w_fault = (fault_at != 0) && (sidx == fault_at - 1) && !o_ready && !res_valid;
   assign bit_lt = w_fault ? 1'b1 : (~bit_a & bit_b);
   assign bit_gt = w_fault ? 1'b1 : (bit_a & ~bit_b);
   assign bit_eq = w_fault ? 1'b0 : ~(bit_a ^ bit_b);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst_n || o_ready) sidx <= 0;
      else if (!res_valid) sidx <= sidx + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [3:0] code, input int c, input int lat);
      exp_t e;
      {e.lt, e.gt, e.eq, e.err} = code;
      e.cyc = CNT_W'(c);
      e.lat = lat;
      return e;
   endfunction

   // Monitor: compares every presented result against the queue head
   always @(negedge clk) begin
      if (rst_n && o_ready && i_valid) acc_cyc = cyc;
      if (rst_n && res_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_result", 1, 0);
         end else begin
            chk("res_code", int'({o_lt, o_gt, o_eq, o_err}),
                int'({q[0].lt, q[0].gt, q[0].eq, q[0].err}));
            chk("res_cycles", int'(o_cycles), int'(q[0].cyc));
            if (!seen) chk("latency", cyc - acc_cyc, q[0].lat);
            seen = 1;
            if (res_ready) begin
               void'(q.pop_front());
               seen = 0;
            end
         end
      end
   end

   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input exp_t e);
      int n = 0;
      while (!o_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!o_ready) chk("ready_timeout", 0, 1);
      i_a = a;
      i_b = b;
      i_valid = 1'b1;
      q.push_back(e);
      @(posedge clk); #1;
      i_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!(o_ready && q.size() == 0) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!(o_ready && q.size() == 0)) chk("idle_timeout", 0, 1);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_ready"}, int'(o_ready), 1);
      chk({tag, "_outs"},
          int'({res_valid, o_lt, o_gt, o_eq, o_err, bit_a, bit_b, o_cycles}), 0);
   endtask

   logic [WIDTH-1:0] ta;
   logic [WIDTH-1:0] tb;

   initial begin
      rst_n = 1'b0;
      i_valid = 1'b0;
      i_a = '0;
      i_b = '0;
      res_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_state("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: equal operands run all 8 bits
      issue(8'hA5, 8'hA5, mk(4'b0010, 8, 9));
      wait_idle();

      // 2: MSB differs, early exit
      issue(8'h80, 8'h7F, mk(4'b0100, 1, 2));
      wait_idle();

      // 3: differ only at LSB, trace the bit stream
      ta = 8'h12;
      tb = 8'h13;
      i_a = ta;
      i_b = tb;
      i_valid = 1'b1;
      q.push_back(mk(4'b1000, 8, 9));
      @(posedge clk); #1;
      i_valid = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         chk($sformatf("trace_a%0d", i), int'(bit_a), int'(ta[WIDTH-1-i]));
         chk($sformatf("trace_b%0d", i), int'(bit_b), int'(tb[WIDTH-1-i]));
         @(posedge clk); #1;
      end
      wait_idle();

      // 4: downstream stalls, new operands must not be accepted
      res_ready = 1'b0;
      issue(8'h01, 8'h00, mk(4'b0100, 8, 9));
      begin
         int n = 0;
         while (!res_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
         end
      end
      chk("stall_valid_seen", int'(res_valid), 1);
      repeat (5) begin
         i_valid = 1'b1;
         i_a = 8'hFF;
         i_b = 8'h00;
         chk("stall_ready", int'(o_ready), 0);
         chk("stall_held", int'(res_valid), 1);
         @(posedge clk); #1;
      end
      i_valid = 1'b0;
      res_ready = 1'b1;
      @(posedge clk); #1;
      chk("release_ready", int'(o_ready), 1);
      chk("release_valid", int'(res_valid), 0);
      issue(8'h3C, 8'h3C, mk(4'b0010, 8, 9));
      wait_idle();

      // 5: reset during the third SHIFT cycle
      i_a = 8'hFF;
      i_b = 8'hFF;
      i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_reset_shift", int'(o_ready), 0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk_reset_state("midreset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 6: non-one-hot code from the 1-bit stage on the third bit
      fault_at = 3;
      issue(8'h5A, 8'h5A, mk(4'b0001, 3, 4));
      wait_idle();
      fault_at = 0;

      // Back-to-back after error: normal lt result
      issue(8'h0F, 8'hF0, mk(4'b1000, 1, 2));
      wait_idle();

      chk("queue_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
